// File: rtl/cycle_counter_reader.sv
// rtl/cycle_counter_reader.sv - 64-bit cycle count from a 32-bit counter, served over a req/resp register port.
// Define CYCLE_COUNTER_READER_CMP_IRQ_EN to add the compare register and timer interrupt.
module cycle_counter_reader #(
   parameter int          HI_W      = 32,
   parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
   input  logic        CLK_IP,
   input  logic        RSTN_IP,
   input  logic [31:0] COUNTER_IP,
   input  logic        REQ_VALID_IP,
   output logic        REQ_READY_OP,
   input  logic        REQ_WE_IP,
   input  logic [1:0]  REQ_ADDR_IP,
   input  logic [31:0] REQ_WDATA_IP,
   output logic        RESP_VALID_OP,
   input  logic        RESP_READY_IP,
   output logic [31:0] RESP_DATA_OP,
   output logic        IRQ_OP
);

   typedef enum logic {IDLE, RESP} state_t;

   state_t            state_q, state_d;
   logic [31:0]       lo_q;
   logic [HI_W-1:0]   hi_q, hi_d;
   logic              prev_msb_q;
   logic [HI_W-1:0]   snap_hi_q, snap_hi_d;
   logic [31:0]       resp_data_q, resp_data_d;
   logic [31:0]       rd_data;
   logic              accept;
   logic              wrap;
   logic [63:0]       count64;

   assign accept  = (state_q == IDLE) && REQ_VALID_IP;
   assign wrap    = prev_msb_q && !COUNTER_IP[31];
   assign count64 = 64'({hi_q, lo_q});

   always_ff @(posedge CLK_IP or negedge RSTN_IP) begin
      if (!RSTN_IP) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (REQ_VALID_IP)  state_d = RESP;
         RESP:    if (RESP_READY_IP) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      REQ_READY_OP  = RSTN_IP && (state_q == IDLE);
      RESP_VALID_OP = (state_q == RESP);
   end

   // Upper count advances on the MSB falling edge of the sampled counter.
   always_comb begin
      hi_d = hi_q;
      if (wrap) hi_d = hi_q + HI_W'(1);
   end

   // The snapshot takes hi_q before this edge's increment, keeping LO/HI coherent across a wrap.
   always_comb begin
      snap_hi_d = snap_hi_q;
      if (accept && !REQ_WE_IP && (REQ_ADDR_IP == 2'd0)) snap_hi_d = hi_q;
   end

`ifdef CYCLE_COUNTER_READER_CMP_IRQ_EN
   logic [63:0] cmp_q, cmp_d;
   logic        irq_q;

   always_comb begin
      cmp_d = cmp_q;
      if (accept && REQ_WE_IP && (REQ_ADDR_IP == 2'd2)) cmp_d[31:0]  = REQ_WDATA_IP;
      if (accept && REQ_WE_IP && (REQ_ADDR_IP == 2'd3)) cmp_d[63:32] = REQ_WDATA_IP;
   end

   always_ff @(posedge CLK_IP or negedge RSTN_IP) begin
      if (!RSTN_IP) begin
         cmp_q <= CMP_RESET;
         irq_q <= 1'b0;
      end else begin
         cmp_q <= cmp_d;
         irq_q <= (count64 >= cmp_q);
      end
   end

   always_comb begin
      rd_data = 32'd0;
      case (REQ_ADDR_IP)
         2'd0: rd_data = lo_q;
         2'd1: rd_data = 32'(snap_hi_q);
         2'd2: rd_data = cmp_q[31:0];
         2'd3: rd_data = cmp_q[63:32];
         default: rd_data = 32'd0;
      endcase
   end

   assign IRQ_OP = irq_q;
`else
   logic unused_cmp;
   assign unused_cmp = ^{REQ_WDATA_IP, CMP_RESET, count64};

   always_comb begin
      rd_data = 32'd0;
      case (REQ_ADDR_IP)
         2'd0: rd_data = lo_q;
         2'd1: rd_data = 32'(snap_hi_q);
         default: rd_data = 32'd0;
      endcase
   end

   assign IRQ_OP = 1'b0;
`endif

   always_comb begin
      resp_data_d = resp_data_q;
      if (accept) resp_data_d = REQ_WE_IP ? 32'd0 : rd_data;
   end

   always_ff @(posedge CLK_IP or negedge RSTN_IP) begin
      if (!RSTN_IP) begin
         lo_q        <= 32'd0;
         hi_q        <= '0;
         prev_msb_q  <= 1'b0;
         snap_hi_q   <= '0;
         resp_data_q <= 32'd0;
      end else begin
         lo_q        <= COUNTER_IP;
         hi_q        <= hi_d;
         prev_msb_q  <= COUNTER_IP[31];
         snap_hi_q   <= snap_hi_d;
         resp_data_q <= resp_data_d;
      end
   end

   assign RESP_DATA_OP = resp_data_q;

endmodule

// File: tb/tb_cycle_counter_reader.sv
// tb/tb_cycle_counter_reader.sv - randomized bench for cycle_counter_reader against a wrap-counting reference model.
module tb_cycle_counter_reader;

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] cnt;
   logic        req_valid, req_we, resp_ready;
   logic [1:0]  req_addr;
   logic [31:0] req_wdata;
   logic        req_ready, resp_valid, irq;
   logic [31:0] resp_data;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   cycle_counter_reader #(.HI_W(32), .CMP_RESET(64'hFFFF_FFFF_FFFF_FFFF)) dut (
      .CLK_IP        (clk),
      .RSTN_IP       (rstn),
      .COUNTER_IP    (cnt),
      .REQ_VALID_IP  (req_valid),
      .REQ_READY_OP  (req_ready),
      .REQ_WE_IP     (req_we),
      .REQ_ADDR_IP   (req_addr),
      .REQ_WDATA_IP  (req_wdata),
      .RESP_VALID_OP (resp_valid),
      .RESP_READY_IP (resp_ready),
      .RESP_DATA_OP  (resp_data),
      .IRQ_OP        (irq)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Reference: extended count = wraps * 2^32 + last sample; a wrap is any decrease of the sample.
   int unsigned m_wraps;
   logic [31:0] m_lo;
   logic [31:0] m_snap;
   logic [63:0] m_cmp;
   logic        m_irq;

   function automatic logic [63:0] m_count();
      return {m_wraps, m_lo};
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_wraps = 0;
         m_lo    = 32'd0;
         m_irq   = 1'b0;
      end else begin
`ifdef CYCLE_COUNTER_READER_CMP_IRQ_EN
         m_irq = (m_count() >= m_cmp);
`else
         m_irq = 1'b0;
`endif
         if (cnt < m_lo) m_wraps++;
         m_lo = cnt;
      end
   end

   logic auto_en = 1'b0;
   always @(negedge clk) begin
      if (auto_en) begin
         if (!cnt[31] && $urandom_range(0, 40) == 0) cnt = 32'hFFFF_FFF0;
         else cnt = cnt + $urandom_range(1, 3);
      end
   end

   logic irq_chk_en = 1'b0;
   always @(negedge clk) begin
      if (irq_chk_en) chk("irq", irq, m_irq);
   end

   task automatic do_reset(input logic [31:0] cval);
      @(negedge clk);
      rstn = 1'b0;
      cnt  = cval;
      m_snap = 32'd0;
      m_cmp  = 64'hFFFF_FFFF_FFFF_FFFF;
      @(negedge clk);
      chk("rst_req_ready", req_ready, 1'b0);
      chk("rst_resp_valid", resp_valid, 1'b0);
      chk("rst_resp_data", resp_data, 32'd0);
      chk("rst_irq", irq, 1'b0);
      rstn = 1'b1;
   endtask

   task automatic do_req(input logic we, input logic [1:0] a, input logic [31:0] wd,
                         input int hold, input logic keep_valid, output logic [31:0] got);
      logic [31:0] exp;
      logic [31:0] hi_pre;
      int guard = 0;
      while (req_ready !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      chk("req_ready", req_ready, 1'b1);
      exp = 32'd0;
      if (!we) begin
         case (a)
            2'd0: exp = m_lo;
            2'd1: exp = m_snap;
`ifdef CYCLE_COUNTER_READER_CMP_IRQ_EN
            2'd2: exp = m_cmp[31:0];
            2'd3: exp = m_cmp[63:32];
`endif
            default: exp = 32'd0;
         endcase
      end
      hi_pre    = m_wraps;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = wd;
      @(negedge clk);
      if (!keep_valid) req_valid = 1'b0;
      if (!we && a == 2'd0) m_snap = hi_pre;
`ifdef CYCLE_COUNTER_READER_CMP_IRQ_EN
      if (we && a == 2'd2) m_cmp[31:0]  = wd;
      if (we && a == 2'd3) m_cmp[63:32] = wd;
`endif
      for (int i = 0; i < hold; i++) begin
         chk("hold_resp_valid", resp_valid, 1'b1);
         chk("hold_resp_data", resp_data, exp);
         chk("hold_req_ready", req_ready, 1'b0);
         @(negedge clk);
      end
      chk("resp_valid", resp_valid, 1'b1);
      chk("resp_data", resp_data, exp);
      got = resp_data;
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk("resp_done", resp_valid, 1'b0);
   endtask

   logic [31:0] got;

   initial begin
      rstn = 1'b1; cnt = 32'd0; req_valid = 1'b0; req_we = 1'b0;
      req_addr = 2'd0; req_wdata = 32'd0; resp_ready = 1'b0;
      m_snap = 32'd0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;

      // Reset with a nonzero counter, then LO after one sample and the cleared HI snapshot.
      do_reset(32'd5);
      irq_chk_en = 1'b1;
      @(negedge clk);
      do_req(1'b0, 2'd0, 32'd0, 0, 1'b0, got);
      chk("first_lo", got, 32'd5);
      do_req(1'b0, 2'd1, 32'd0, 0, 1'b0, got);
      chk("first_hi", got, 32'd0);

      // Wrap sequence bumps the upper count.
      cnt = 32'hFFFF_FFFE; @(negedge clk);
      cnt = 32'hFFFF_FFFF; @(negedge clk);
      cnt = 32'h0000_0000; @(negedge clk);
      cnt = 32'h0000_0001; @(negedge clk);
      do_req(1'b0, 2'd0, 32'd0, 0, 1'b0, got);
      chk("wrap_lo", got, 32'd1);
      do_req(1'b0, 2'd1, 32'd0, 0, 1'b0, got);
      chk("wrap_hi", got, 32'd1);

      // LO read on the same edge as the wrap returns pre-wrap values.
      do_reset(32'd0);
      cnt = 32'hFFFF_FFFF; @(negedge clk);
      @(negedge clk);
      cnt = 32'h0000_0000;
      do_req(1'b0, 2'd0, 32'd0, 0, 1'b0, got);
      chk("edge_lo", got, 32'hFFFF_FFFF);
      do_req(1'b0, 2'd1, 32'd0, 0, 1'b0, got);
      chk("edge_hi_old", got, 32'd0);
      do_req(1'b0, 2'd0, 32'd0, 0, 1'b0, got);
      do_req(1'b0, 2'd1, 32'd0, 0, 1'b0, got);
      chk("edge_hi_new", got, 32'd1);

      // Backpressure with REQ_VALID held high, then re-acceptance on return to IDLE.
      cnt = 32'h1234_5678;
      @(negedge clk);
      do_req(1'b0, 2'd0, 32'd0, 5, 1'b1, got);
      chk("bp_data", got, 32'h1234_5678);
      chk("bp_ready_idle", req_ready, 1'b1);
      do_req(1'b0, 2'd1, 32'd0, 0, 1'b0, got);
      chk("bp_second_hi", got, 32'd1);

      do_reset(32'd10);
`ifdef CYCLE_COUNTER_READER_CMP_IRQ_EN
      do_req(1'b1, 2'd3, 32'd0, 0, 1'b0, got);
      chk("wr_data0", got, 32'd0);
      do_req(1'b1, 2'd2, 32'd100, 0, 1'b0, got);
      do_req(1'b0, 2'd2, 32'd0, 0, 1'b0, got);
      chk("cmp_lo_rd", got, 32'd100);
      begin
         int guard = 0;
         while (cnt < 32'd120 && guard < 300) begin
            cnt = cnt + 32'd1;
            @(negedge clk);
            guard++;
         end
      end
      chk("irq_rise", irq, 1'b1);
      do_req(1'b1, 2'd2, 32'd1000, 0, 1'b0, got);
      @(negedge clk);
      chk("irq_fall", irq, 1'b0);
`else
      do_req(1'b1, 2'd2, 32'd100, 0, 1'b0, got);
      chk("wr_data0", got, 32'd0);
      do_req(1'b0, 2'd2, 32'd0, 0, 1'b0, got);
      chk("cmp_absent_rd", got, 32'd0);
      for (int i = 0; i < 150; i++) begin
         cnt = cnt + 32'd1;
         @(negedge clk);
      end
      chk("irq_off", irq, 1'b0);
`endif

      // Randomized traffic with a moving counter.
      do_reset(32'd0);
      auto_en = 1'b1;
      for (int t = 0; t < 200; t++) begin
         logic        we;
         logic [1:0]  a;
         logic [31:0] wd;
         we = ($urandom_range(0, 3) == 0);
         a  = 2'($urandom_range(0, 3));
         wd = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 4000) : $urandom;
         do_req(we, a, wd, $urandom_range(0, 3), 1'b0, got);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      auto_en = 1'b0;
      irq_chk_en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
